// File: rtl/edge_event_counter.sv
// Event counter behind the rising-edge detector: count, compare-match pulse, sticky interrupt.
// Optional overflow status is built only when EDGE_CNT_OVF_EN is defined; otherwise o_ovf is tied 0.
module edge_event_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_pulse,
    input  logic                 i_clr,
    input  logic                 i_auto_reload,
    input  logic [CNT_WIDTH-1:0] i_cmp_val,
    input  logic                 i_int_en,
    input  logic                 i_int_clr,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_match,
    output logic                 o_int_st,
    output logic                 o_int,
    output logic                 o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 match_d;
    logic                 int_st_d;
    logic                 hit;

    assign count_inc = o_count + CNT_WIDTH'(1);
    assign hit       = (i_cmp_val != '0) && (count_inc == i_cmp_val);

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            o_count  <= '0;
            o_match  <= 1'b0;
            o_int_st <= 1'b0;
            o_int    <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_count  <= count_d;
            o_match  <= match_d;
            o_int_st <= int_st_d;
            o_int    <= o_int_st & i_int_en;
        end
    end

    // Next state and next register values; clear beats disable beats pulse
    always_comb begin
        state_d  = state_q;
        count_d  = o_count;
        match_d  = 1'b0;
        int_st_d = o_int_st;
        if (i_int_clr) begin
            int_st_d = 1'b0;
        end

        if (i_clr) begin
            count_d = '0;
            state_d = i_en ? ST_RUN : ST_IDLE;
        end else if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (i_pulse) begin
                        if (hit) begin
                            match_d  = 1'b1;
                            int_st_d = 1'b1;
                            if (i_auto_reload) begin
                                count_d = '0;
                            end else begin
                                count_d = i_cmp_val;
                                state_d = ST_HALT;
                            end
                        end else begin
                            count_d = count_inc;
                        end
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef EDGE_CNT_OVF_EN
    logic ovf_q;

    // Sticky wrap flag; a counted pulse at all-ones can never match a nonzero compare
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (i_clr) begin
            ovf_q <= 1'b0;
        end else if (i_en && (state_q == ST_RUN) && i_pulse && (&o_count) && !hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench for edge_event_counter (CNT_WIDTH=4): vector table plus hand-written corner sequences.
module tb_edge_event_counter;

    localparam int unsigned W = 4;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, pulse, clr, ar, int_en, int_clr;
    logic [W-1:0] cmp;
    logic [W-1:0] count;
    logic         match, int_st, intr, ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string    name;
        bit       en;
        bit       pulse;
        bit       clr;
        bit       ar;
        bit [W-1:0] cmp;
        bit       int_clr;
        bit [W-1:0] exp_count;
        bit       exp_match;
        bit       exp_int_st;
    } vec_t;

    vec_t vecs[$];

    edge_event_counter #(.CNT_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_pulse      (pulse),
        .i_clr        (clr),
        .i_auto_reload(ar),
        .i_cmp_val    (cmp),
        .i_int_en     (int_en),
        .i_int_clr    (int_clr),
        .o_count      (count),
        .o_match      (match),
        .o_int_st     (int_st),
        .o_int        (intr),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input bit e, input bit p, input bit c, input bit a,
                       input bit [W-1:0] cv, input bit ic, input bit [W-1:0] ec,
                       input bit em, input bit ei);
        vec_t v;
        v.name = n; v.en = e; v.pulse = p; v.clr = c; v.ar = a; v.cmp = cv;
        v.int_clr = ic; v.exp_count = ec; v.exp_match = em; v.exp_int_st = ei;
        vecs.push_back(v);
    endtask

    initial begin
        logic exp_ovf;
`ifdef EDGE_CNT_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // basic count, compare 5, halt
        add("en_rise",      H, H, L, L, 4'd5, L, 4'd0, L, L);
        add("cnt1",         H, H, L, L, 4'd5, L, 4'd1, L, L);
        add("cnt2",         H, H, L, L, 4'd5, L, 4'd2, L, L);
        add("cnt3",         H, H, L, L, 4'd5, L, 4'd3, L, L);
        add("cnt4",         H, H, L, L, 4'd5, L, 4'd4, L, L);
        add("match5",       H, H, L, L, 4'd5, L, 4'd5, H, H);
        add("halt_hold",    H, H, L, L, 4'd5, L, 4'd5, L, H);
        add("halt_clr",     H, L, H, L, 4'd5, L, 4'd0, L, H);
        // auto-reload, compare 3
        add("ar_p1",        H, H, L, H, 4'd3, L, 4'd1, L, H);
        add("ar_p2",        H, H, L, H, 4'd3, L, 4'd2, L, H);
        add("ar_p3",        H, H, L, H, 4'd3, L, 4'd0, H, H);
        add("ar_p4",        H, H, L, H, 4'd3, L, 4'd1, L, H);
        add("ar_p5",        H, H, L, H, 4'd3, L, 4'd2, L, H);
        add("ar_p6",        H, H, L, H, 4'd3, L, 4'd0, H, H);
        add("ar_p7",        H, H, L, H, 4'd3, L, 4'd1, L, H);
        add("int_clr",      H, L, L, H, 4'd3, H, 4'd1, L, L);
        // collisions
        add("pre_col",      H, H, L, H, 4'd3, L, 4'd2, L, L);
        add("clr_pulse",    H, H, H, H, 4'd3, L, 4'd0, L, L);
        add("col_p1",       H, H, L, H, 4'd3, L, 4'd1, L, L);
        add("col_p2",       H, H, L, H, 4'd3, L, 4'd2, L, L);
        add("intclr_match", H, H, L, H, 4'd3, H, 4'd0, H, H);
        add("en_low_pulse", L, H, L, H, 4'd3, L, 4'd0, L, H);
        add("en_rise2",     H, H, L, H, 4'd3, L, 4'd0, L, H);
        add("cnt_after",    H, H, L, H, 4'd3, L, 4'd1, L, H);
        add("cmp_lower",    H, H, L, L, 4'd1, L, 4'd2, L, H);

        rst = 1'b1; en = 1'b0; pulse = 1'b0; clr = 1'b0; ar = 1'b0;
        cmp = '0; int_en = 1'b0; int_clr = 1'b0;
        step();
        step();
        check("rst_count",  32'(count),  32'd0);
        check("rst_match",  32'(match),  32'd0);
        check("rst_int_st", 32'(int_st), 32'd0);
        check("rst_int",    32'(intr),   32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            en = vecs[i].en; pulse = vecs[i].pulse; clr = vecs[i].clr; ar = vecs[i].ar;
            cmp = vecs[i].cmp; int_clr = vecs[i].int_clr;
            step();
            check({vecs[i].name, "_count"},  32'(count),  32'(vecs[i].exp_count));
            check({vecs[i].name, "_match"},  32'(match),  32'(vecs[i].exp_match));
            check({vecs[i].name, "_int_st"}, 32'(int_st), 32'(vecs[i].exp_int_st));
            check({vecs[i].name, "_ovf"},    32'(ovf),    32'd0);
        end

        // interrupt gating
        en = 1'b1; pulse = 1'b0; ar = 1'b0; int_clr = 1'b1;
        step();
        check("ig_clear_st", 32'(int_st), 32'd0);
        int_clr = 1'b0; cmp = 4'd2; clr = 1'b1;
        step();
        clr = 1'b0; pulse = 1'b1;
        step();
        step();
        check("ig_match",    32'(match),  32'd1);
        check("ig_st_set",   32'(int_st), 32'd1);
        pulse = 1'b0;
        step();
        check("ig_int_gated", 32'(intr), 32'd0);
        int_en = 1'b1;
        step();
        check("ig_int_on",   32'(intr), 32'd1);
        int_clr = 1'b1;
        step();
        check("ig_st_cleared", 32'(int_st), 32'd0);
        check("ig_int_lag",  32'(intr), 32'd1);
        int_clr = 1'b0;
        step();
        check("ig_int_off",  32'(intr), 32'd0);
        int_en = 1'b0;

        // overflow with compare disabled
        cmp = 4'd0; clr = 1'b1;
        step();
        clr = 1'b0; pulse = 1'b1;
        check("ov_start_count", 32'(count), 32'd0);
        for (int k = 0; k < 15; k++) step();
        check("ov_15_count", 32'(count), 32'd15);
        check("ov_15_flag",  32'(ovf),   32'd0);
        step();
        check("ov_16_count", 32'(count), 32'd0);
        check("ov_16_flag",  32'(ovf),   32'(exp_ovf));
        step();
        check("ov_17_count", 32'(count), 32'd1);
        check("ov_17_flag",  32'(ovf),   32'(exp_ovf));
        check("ov_17_match", 32'(match), 32'd0);
        pulse = 1'b0; clr = 1'b1;
        step();
        check("ov_clr_flag",  32'(ovf),   32'd0);
        check("ov_clr_count", 32'(count), 32'd0);
        clr = 1'b0;

        // asynchronous reset mid-count
        pulse = 1'b1;
        for (int k = 0; k < 9; k++) step();
        check("mr_pre_count", 32'(count), 32'd9);
        pulse = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mr_count",  32'(count),  32'd0);
        check("mr_match",  32'(match),  32'd0);
        check("mr_int_st", 32'(int_st), 32'd0);
        check("mr_int",    32'(intr),   32'd0);
        check("mr_ovf",    32'(ovf),    32'd0);
        step();
        rst = 1'b0;
        step();
        check("mr_idle_count", 32'(count), 32'd0);
        pulse = 1'b1;
        step();
        check("mr_first_pulse", 32'(count), 32'd1);
        pulse = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
